// File: rtl/bcd_display_driver.sv
// bcd_display_driver: iterative double-dabble binary-to-BCD converter driving DIGITS active-low 7-segment glyphs
module bcd_display_driver #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [WIDTH-1:0]      i_value,
  input  logic                  i_load,
  input  logic                  i_signed_mode,
  input  logic                  i_blank_lz,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic                  o_overflow,
  output logic [7*DIGITS-1:0]   o_d
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(WIDTH+1);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b1111110;
  typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} state_t;
  state_t              r_state, w_state_nxt;
  logic [WIDTH-1:0]    r_mag;
  logic [BW-1:0]       r_bcd, w_adj;
  logic [CW-1:0]       r_cnt;
  logic                r_neg, r_blz, r_sticky, r_valid, r_ovf, w_ovf, w_any;
  logic [7*DIGITS-1:0] r_d, w_frame;
  logic [DIGITS-1:0]   w_show, w_below;
  function automatic logic [6:0] f_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return BLANK;
    endcase
  endfunction
  always_comb begin
    w_state_nxt = (r_state == IDLE)  ? (i_load ? SHIFT : IDLE) :
                  (r_state == SHIFT) ? ((r_cnt == CW'(1)) ? FORMAT : SHIFT) : IDLE;
  end
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++)
      w_adj[4*k+:4] = (r_bcd[4*k+:4] >= 4'd5) ? r_bcd[4*k+:4] + 4'd3 : r_bcd[4*k+:4];
  end
  // w_show[k]: digit k is at or below the most significant nonzero digit (digit 0 always shown);
  // w_below[k]: digit k sits immediately left of that region, where a minus sign goes
  always_comb begin
    w_ovf   = r_sticky | (r_neg & (|r_bcd[BW-1 -: 4]));
    w_any   = 1'b0;
    w_show  = '0;
    w_frame = '1;
    for (int k = DIGITS-1; k >= 0; k--) begin
      w_any     = w_any | (|r_bcd[4*k+:4]) | (k == 0);
      w_show[k] = w_any;
    end
    w_below = {w_show[DIGITS-2:0], 1'b0} & ~w_show;
    for (int k = 0; k < DIGITS; k++)
      w_frame[7*k+:7] = w_ovf                 ? DASH :
                        !r_blz                ? ((r_neg && k == DIGITS-1) ? DASH : f_seg(r_bcd[4*k+:4])) :
                        w_show[k]             ? f_seg(r_bcd[4*k+:4]) :
                        (r_neg && w_below[k]) ? DASH : BLANK;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_mag    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_blz    <= 1'b0;
      r_sticky <= 1'b0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
      r_d      <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= 1'b0;
      if (r_state == IDLE && i_load) begin
        r_mag    <= (i_signed_mode && i_value[WIDTH-1]) ? -i_value : i_value;
        r_neg    <= i_signed_mode & i_value[WIDTH-1];
        r_blz    <= i_blank_lz;
        r_bcd    <= '0;
        r_sticky <= 1'b0;
        r_cnt    <= CW'(WIDTH);
      end
      if (r_state == SHIFT) begin
        {r_bcd, r_mag} <= {w_adj[BW-2:0], r_mag, 1'b0};
        r_sticky       <= r_sticky | w_adj[BW-1];
        r_cnt          <= r_cnt - CW'(1);
      end
      if (r_state == FORMAT) begin
        r_d     <= w_frame;
        r_ovf   <= w_ovf;
        r_valid <= 1'b1;
      end
    end
  end
  assign o_busy     = (r_state != IDLE);
  assign o_valid    = r_valid;
  assign o_overflow = r_ovf;
  assign o_d        = r_d;
endmodule
